exp_arbiter: RTL and testbench

- Shares one Exponential core (start/done handshake, combinational operand input) among N_REQ requesters, e.g. parallel softmax lanes of the MNIST classifier output stage.
- Round-robin arbitration, registered operand held stable for the whole core computation, per-requester valid/ready request and response channels.
- Watchdog flags a core that never completes.

---
 rtl/exp_arbiter_pkg.sv | 20 ++
 rtl/rr_priority_arbiter.sv | 38 +++
 rtl/exp_arbiter.sv | 136 +++++++++++++
 tb/tb_exp_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_arbiter_pkg.sv
// Shared definitions for the exponential-core arbiter: FSM encoding, index sizing
// and Q.30 fixed-point reference constants.
package exp_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Q.30 reference points for models of the exponential core.
    localparam logic signed [63:0] FX_ONE    = 64'sd1073741824;
    localparam logic signed [63:0] FX_MINUS6 = -64'sd6442450944;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_arbiter.sv
// Combinational round-robin priority pick: the first asserted request at or after
// the pointer, wrapping, returned both one-hot and as an index.
module rr_priority_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_slot;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_slot  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            // Extra sum bit keeps the wrap correct for non power-of-two N_REQ.
            w_sum = {1'b0, i_ptr} + (IDX_W+1)'(k);
            if (w_sum >= (IDX_W+1)'(N_REQ)) begin
                w_sum = w_sum - (IDX_W+1)'(N_REQ);
            end
            w_slot = w_sum[IDX_W-1:0];
            if (!o_any && i_req[w_slot]) begin
                o_any           = 1'b1;
                o_grant[w_slot] = 1'b1;
                o_idx           = w_slot;
            end
        end
    end

endmodule

// File: rtl/exp_arbiter.sv
// Round-robin sharing of one start/done exponential core among N_REQ requesters,
// with a held operand register, per-requester response channels and a watchdog.
module exp_arbiter
    import exp_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int FRACTION_BITS = 30,
    parameter int N_REQ         = 4,
    parameter int TIMEOUT       = 1023
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_REQ-1:0]              i_req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   i_req_data,
    output logic [N_REQ-1:0]              o_req_ready,
    output logic [N_REQ-1:0]              o_resp_valid,
    input  logic [N_REQ-1:0]              i_resp_ready,
    output logic signed [DATA_WIDTH-1:0]  o_resp_data,
    output logic                          o_exp_start,
    output logic signed [DATA_WIDTH-1:0]  o_exp_in,
    input  logic                          i_exp_done,
    input  logic signed [DATA_WIDTH-1:0]  i_exp_out,
    output logic                          o_busy,
    output logic                          o_timeout_err
);

    localparam int IDX_W   = idx_width(N_REQ);
    localparam int WD_W    = idx_width(TIMEOUT + 1);
    localparam int WD_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    if (N_REQ < 2 || N_REQ > 16 || FRACTION_BITS >= DATA_WIDTH) begin : g_bad_cfg
        $error("exp_arbiter: unsupported parameter combination");
    end

    arb_state_e                   r_state;
    logic [IDX_W-1:0]             r_rr_ptr;
    logic [IDX_W-1:0]             r_grant;
    logic signed [DATA_WIDTH-1:0] r_op;
    logic signed [DATA_WIDTH-1:0] r_res;
    logic [WD_W-1:0]              r_wd_cnt;
    logic                         r_exp_start;
    logic [N_REQ-1:0]             r_resp_valid;
    logic                         r_timeout_err;

    logic [N_REQ-1:0]             w_arb_grant;
    logic [IDX_W-1:0]             w_arb_idx;
    logic                         w_arb_any;
    logic signed [DATA_WIDTH-1:0] w_sel_data;
    logic [N_REQ-1:0]             w_grant_oh;
    logic [IDX_W-1:0]             w_next_ptr;
    logic                         w_wd_expire;
    logic                         w_idle;

    rr_priority_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_arb_grant),
        .o_idx   (w_arb_idx),
        .o_any   (w_arb_any)
    );

    assign w_idle      = (r_state == ST_IDLE);
    assign w_sel_data  = i_req_data[w_arb_idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_grant_oh  = N_REQ'(1) << r_grant;
    assign w_next_ptr  = (r_grant == IDX_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
    assign w_wd_expire = (TIMEOUT != 0) && (r_wd_cnt == WD_W'(WD_LAST));

    // Ready is masked while reset is held so every output reads zero during reset.
    assign o_req_ready   = (w_idle && rst_n) ? w_arb_grant : '0;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_data   = r_res;
    assign o_exp_start   = r_exp_start;
    assign o_exp_in      = r_op;
    assign o_busy        = !w_idle;
    assign o_timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= '0;
            r_grant       <= '0;
            r_op          <= '0;
            r_res         <= '0;
            r_wd_cnt      <= '0;
            r_exp_start   <= 1'b0;
            r_resp_valid  <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_exp_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_arb_any) begin
                        r_op        <= w_sel_data;
                        r_grant     <= w_arb_idx;
                        r_wd_cnt    <= '0;
                        r_exp_start <= 1'b1;
                        r_state     <= ST_START;
                    end
                end
                ST_START: begin
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_wd_cnt != '1) begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                    // A zero count marks the first WAIT cycle, where the core is still in INIT.
                    if ((r_wd_cnt != '0) && i_exp_done) begin
                        r_res        <= i_exp_out;
                        r_resp_valid <= w_grant_oh;
                        r_state      <= ST_RESP;
                    end else if (w_wd_expire) begin
                        r_timeout_err <= 1'b1;
                        r_res         <= '0;
                        r_resp_valid  <= w_grant_oh;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (i_resp_ready[r_grant]) begin
                        r_rr_ptr     <= w_next_ptr;
                        r_resp_valid <= '0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exp_arbiter.sv
// Directed bench for exp_arbiter with a behavioural exponential core and a
// scoreboard of expected responses filled at acceptance time.
module tb_exp_arbiter;
    import exp_arbiter_pkg::*;

    localparam int DW   = 36;
    localparam int FB   = 30;
    localparam int N    = 4;
    localparam int TO   = 15;
    localparam int ITER = 6;

    localparam logic signed [DW-1:0] ONE    = FX_ONE[DW-1:0];
    localparam logic signed [DW-1:0] MINUS6 = FX_MINUS6[DW-1:0];
    localparam logic signed [DW-1:0] HALF   = ONE >>> 1;
    localparam logic signed [DW-1:0] M65    = MINUS6 - HALF;
    localparam logic signed [DW-1:0] M7     = MINUS6 - ONE;

    typedef struct {
        int                   idx;
        logic signed [DW-1:0] data;
    } sb_t;

    logic                  clk;
    logic                  rst_n;
    logic [N-1:0]          req_valid;
    logic [N*DW-1:0]       req_data;
    logic [N-1:0]          req_ready;
    logic [N-1:0]          resp_valid;
    logic [N-1:0]          resp_ready;
    logic signed [DW-1:0]  resp_data;
    logic                  exp_start;
    logic signed [DW-1:0]  exp_in;
    logic                  exp_done;
    logic signed [DW-1:0]  exp_out;
    logic                  busy;
    logic                  timeout_err;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  start_cnt = 0;
    int  core_cnt = 0;
    logic core_hang = 1'b0;
    logic exp_in_bad = 1'b0;
    logic signed [DW-1:0] core_op = '0;
    sb_t sb_q[$];

    exp_arbiter #(
        .DATA_WIDTH    (DW),
        .FRACTION_BITS (FB),
        .N_REQ         (N),
        .TIMEOUT       (TO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_valid   (req_valid),
        .i_req_data    (req_data),
        .o_req_ready   (req_ready),
        .o_resp_valid  (resp_valid),
        .i_resp_ready  (resp_ready),
        .o_resp_data   (resp_data),
        .o_exp_start   (exp_start),
        .o_exp_in      (exp_in),
        .i_exp_done    (exp_done),
        .i_exp_out     (exp_out),
        .o_busy        (busy),
        .o_timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (exp_start) start_cnt <= start_cnt + 1;

    function automatic logic signed [DW-1:0] exp_model(input logic signed [DW-1:0] x);
        longint xl;
        real    r;
        if (x <= MINUS6) return '0;
        xl = x;
        r  = real'(xl) / 1073741824.0;
        r  = $exp(r) * 1073741824.0;
        xl = longint'(r);
        return xl[DW-1:0];
    endfunction

    // Core model: INIT for one cycle after start, then a fixed iteration count,
    // or straight back to idle for operands at or below -6.0.
    assign exp_done = (core_cnt == 0);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_cnt <= 0;
            exp_out  <= '0;
        end else if (exp_start) begin
            core_cnt <= (exp_in <= MINUS6) ? 1 : 1 + ITER;
            core_op  <= exp_in;
        end else if (core_cnt > 0) begin
            if (!core_hang && (exp_in !== core_op)) exp_in_bad <= 1'b1;
            if (!core_hang) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) exp_out <= exp_model(core_op);
            end
        end
    end

    function automatic logic [N-1:0] oh(input int i);
        oh = '0;
        if (i >= 0 && i < N) oh[i] = 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic accept(input int idx, input logic signed [DW-1:0] op,
                          input logic signed [DW-1:0] expv, output int acc);
        sb_t e;
        int  n;
        n = 0;
        req_data[idx*DW +: DW] = op;
        req_valid[idx] = 1'b1;
        #1;
        while (req_ready == '0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready", {60'd0, req_ready}, {60'd0, oh(idx)});
        e.idx  = idx;
        e.data = expv;
        sb_q.push_back(e);
        acc = cyc;
        @(posedge clk); #1;
        req_valid[idx] = 1'b0;
    endtask

    task automatic wait_resp(input int budget, output logic signed [DW-1:0] d, output int rc);
        sb_t e;
        int  n;
        n = 0;
        while (resp_valid == '0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
        end else begin
            e.idx  = -1;
            e.data = 'x;
        end
        chk("resp_valid", {60'd0, resp_valid}, {60'd0, oh(e.idx)});
        chk("resp_data", 64'(resp_data), 64'(e.data));
        d  = resp_data;
        rc = cyc;
    endtask

    task automatic ack(input int idx);
        resp_ready[idx] = 1'b1;
        @(posedge clk); #1;
        resp_ready[idx] = 1'b0;
        chk("resp_released", {60'd0, resp_valid}, 64'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req_ready"},   {60'd0, req_ready}, 64'd0);
        chk({tag, "_resp_valid"},  {60'd0, resp_valid}, 64'd0);
        chk({tag, "_resp_data"},   64'(resp_data), 64'd0);
        chk({tag, "_exp_start"},   {63'd0, exp_start}, 64'd0);
        chk({tag, "_exp_in"},      64'(exp_in), 64'd0);
        chk({tag, "_busy"},        {63'd0, busy}, 64'd0);
        chk({tag, "_timeout_err"}, {63'd0, timeout_err}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish in time");
    end

    initial begin
        logic signed [DW-1:0] d;
        logic signed [DW-1:0] lane_op [N];
        int rr_order [5];
        int a, r, s;

        rst_n      = 1'b0;
        req_valid  = '0;
        req_data   = '0;
        resp_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Round robin from pointer 0 with every requester valid.
        lane_op  = '{ONE, -ONE, HALF, M65};
        rr_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = lane_op[i];
        req_valid = '1;
        #1;
        for (int t = 0; t < 5; t++) begin
            sb_t e;
            int  n;
            n = 0;
            while (req_ready == '0 && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            chk("rr_grant", {60'd0, req_ready}, {60'd0, oh(rr_order[t])});
            e.idx  = rr_order[t];
            e.data = exp_model(lane_op[rr_order[t]]);
            sb_q.push_back(e);
            @(posedge clk); #1;
            if (t == 4) req_valid = '0;
            wait_resp(40, d, r);
            ack(rr_order[t]);
        end

        // Single request, exp(0.0).
        s = start_cnt;
        accept(0, '0, exp_model('0), a);
        wait_resp(40, d, r);
        chk("exp0_value", 64'(d), 64'(ONE));
        chk("exp0_latency", 64'(r - a), 64'(4 + ITER));
        ack(0);
        chk("exp0_starts", 64'(start_cnt - s), 64'd1);

        // Operand below -6.0 takes the short core path.
        accept(2, M7, '0, a);
        wait_resp(40, d, r);
        chk("m7_latency", 64'(r - a), 64'd4);
        ack(2);

        // Response back-pressure with competing requests and foreign acks.
        accept(1, HALF, exp_model(HALF), a);
        wait_resp(40, d, r);
        req_valid  = '1;
        resp_ready = ~oh(1);
        s = start_cnt;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("stall_resp_valid", {60'd0, resp_valid}, {60'd0, oh(1)});
            chk("stall_resp_data", 64'(resp_data), 64'(d));
            chk("stall_req_ready", {60'd0, req_ready}, 64'd0);
        end
        chk("stall_no_start", 64'(start_cnt - s), 64'd0);
        req_valid  = '0;
        resp_ready = '0;
        ack(1);

        // Core that never completes trips the watchdog.
        core_hang = 1'b1;
        accept(3, ONE, '0, a);
        chk("to_err_before", {63'd0, timeout_err}, 64'd0);
        wait_resp(40, d, r);
        chk("to_latency", 64'(r - a), 64'(2 + TO));
        chk("to_err_set", {63'd0, timeout_err}, 64'd1);
        ack(3);
        accept(0, -ONE, exp_model(-ONE), a);
        core_hang = 1'b0;
        wait_resp(40, d, r);
        chk("after_to_latency", 64'(r - a), 64'(4 + ITER));
        chk("to_err_sticky", {63'd0, timeout_err}, 64'd1);
        ack(0);

        // Asynchronous reset while waiting on the core.
        accept(1, HALF, exp_model(HALF), a);
        repeat (2) @(posedge clk);
        #1;
        chk("pre_reset_busy", {63'd0, busy}, 64'd1);
        chk("pre_reset_exp_in", 64'(exp_in), 64'(HALF));
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1;
        chk("in_reset_resp_valid", {60'd0, resp_valid}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        accept(3, M65, '0, a);
        wait_resp(40, d, r);
        chk("post_reset_latency", 64'(r - a), 64'd4);
        ack(3);

        chk("exp_in_stable", {63'd0, exp_in_bad}, 64'd0);
        chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
